// File: rtl/vrf_elem_streamer.sv
`default_nettype none
// ============================================================================
// Module   : vrf_elem_streamer
// Brief    : Walks one vector register through a VRF read port and streams
//            its SEW-wide elements in index order over valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module vrf_elem_streamer #(
  parameter int ELEN      = 64,
  parameter int N_LANES   = 8,
  parameter int N_BANKS   = 5,
  parameter int BANK_SIZE = 80,
  parameter int NVREGS    = 32,
  parameter int MAX_VLEN  = 16384
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [$clog2(NVREGS)-1:0]      req_vreg,
  input  logic [1:0]                     req_sew,
  input  logic [$clog2(MAX_VLEN/8):0]    req_vl,
  output logic                           rd_en,
  output logic [$clog2(N_LANES)-1:0]     rd_lane,
  output logic [$clog2(N_BANKS)-1:0]     rd_bank,
  output logic [$clog2(BANK_SIZE)-1:0]   rd_addr,
  input  logic [ELEN-1:0]                rd_data,
  output logic                           elem_valid,
  input  logic                           elem_ready,
  output logic [ELEN-1:0]                elem_data,
  output logic [$clog2(MAX_VLEN/8)-1:0]  elem_idx,
  output logic                           elem_last,
  output logic                           done,
  output logic                           err
);

  localparam int c_VL_W          = $clog2(MAX_VLEN/8) + 1;
  localparam int c_IDX_W         = c_VL_W - 1;
  localparam int c_VREG_W        = $clog2(NVREGS);
  localparam int c_LANE_W        = $clog2(N_LANES);
  localparam int c_BANK_W        = $clog2(N_BANKS);
  localparam int c_ADDR_W        = $clog2(BANK_SIZE);
  localparam int c_BLK_PER_BANK  = (MAX_VLEN/ELEN + N_LANES*N_BANKS - 1) / (N_LANES*N_BANKS);
  localparam int c_ROW_W         = $clog2(c_BLK_PER_BANK + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_VREG_W-1:0]   r_vreg;
  logic [1:0]            r_sew;
  logic [c_VL_W-1:0]     r_vl;
  logic [c_VL_W-1:0]     r_elem;
  logic [3:0]            r_k;
  logic [ELEN-1:0]       r_buf;
  logic [c_LANE_W-1:0]   r_lane;
  logic [c_BANK_W-1:0]   r_bank;
  logic [c_ROW_W-1:0]    r_row;
  logic                  r_err;

  logic [c_VL_W-1:0]     w_sew_max;
  logic                  w_req_bad;
  logic [3:0]            w_per_blk;
  logic [c_VL_W-1:0]     w_rem;
  logic [3:0]            w_k_init;
  logic                  w_last;
  logic [ELEN-1:0]       w_elem_raw;
  logic [ELEN-1:0]       w_buf_shift;

  // Legality limit is on the incoming SEW; per-word element count on the captured one
  always_comb begin
    w_sew_max = c_VL_W'(MAX_VLEN/64);
    case (req_sew)
      2'd0:    w_sew_max = c_VL_W'(MAX_VLEN/8);
      2'd1:    w_sew_max = c_VL_W'(MAX_VLEN/16);
      2'd2:    w_sew_max = c_VL_W'(MAX_VLEN/32);
      default: w_sew_max = c_VL_W'(MAX_VLEN/64);
    endcase
  end

  assign w_req_bad = (req_vl > w_sew_max);

  always_comb begin
    w_per_blk   = 4'd1;
    w_elem_raw  = r_buf;
    w_buf_shift = '0;
    case (r_sew)
      2'd0: begin
        w_per_blk   = 4'd8;
        w_elem_raw  = ELEN'(r_buf[7:0]);
        w_buf_shift = r_buf >> 8;
      end
      2'd1: begin
        w_per_blk   = 4'd4;
        w_elem_raw  = ELEN'(r_buf[15:0]);
        w_buf_shift = r_buf >> 16;
      end
      2'd2: begin
        w_per_blk   = 4'd2;
        w_elem_raw  = ELEN'(r_buf[31:0]);
        w_buf_shift = r_buf >> 32;
      end
      default: begin
        w_per_blk   = 4'd1;
        w_elem_raw  = r_buf;
        w_buf_shift = '0;
      end
    endcase
  end

  assign w_rem    = r_vl - r_elem;
  assign w_k_init = (w_rem < c_VL_W'(w_per_blk)) ? w_rem[3:0] : w_per_blk;
  assign w_last   = (r_elem == (r_vl - c_VL_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rd_en       = 1'b0;
    elem_valid  = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_vl == '0) begin
            w_state_nxt = S_DONE;
          end else if (!w_req_bad) begin
            w_state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        rd_en       = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        elem_valid = 1'b1;
        if (elem_ready && (r_k == 4'd1)) begin
          w_state_nxt = w_last ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Block walk: lane fastest, then bank, then row within the vreg's address window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vreg <= '0;
      r_sew  <= '0;
      r_vl   <= '0;
      r_elem <= '0;
      r_k    <= '0;
      r_buf  <= '0;
      r_lane <= '0;
      r_bank <= '0;
      r_row  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_vreg <= req_vreg;
            r_sew  <= req_sew;
            r_vl   <= req_vl;
            r_elem <= '0;
            r_lane <= '0;
            r_bank <= '0;
            r_row  <= '0;
            r_err  <= w_req_bad;
          end
        end
        S_WAIT: begin
          r_buf <= rd_data;
          r_k   <= w_k_init;
        end
        S_EMIT: begin
          if (elem_ready) begin
            r_buf  <= w_buf_shift;
            r_elem <= r_elem + c_VL_W'(1);
            r_k    <= r_k - 4'd1;
            if (r_k == 4'd1) begin
              if (r_lane == c_LANE_W'(N_LANES-1)) begin
                r_lane <= '0;
                if (r_bank == c_BANK_W'(N_BANKS-1)) begin
                  r_bank <= '0;
                  r_row  <= r_row + c_ROW_W'(1);
                end else begin
                  r_bank <= r_bank + c_BANK_W'(1);
                end
              end else begin
                r_lane <= r_lane + c_LANE_W'(1);
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_lane   = rd_en ? r_lane : '0;
  assign rd_bank   = rd_en ? r_bank : '0;
  assign rd_addr   = rd_en ? (c_ADDR_W'(r_vreg) * c_ADDR_W'(c_BLK_PER_BANK) + c_ADDR_W'(r_row)) : '0;
  assign elem_data = elem_valid ? w_elem_raw : '0;
  assign elem_idx  = elem_valid ? r_elem[c_IDX_W-1:0] : '0;
  assign elem_last = elem_valid && w_last;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vrf_elem_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vrf_elem_streamer
// Brief    : Directed scoreboard bench for vrf_elem_streamer.
// Revision : 1.0  initial release
// ============================================================================
module tb_vrf_elem_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_vreg = '0;
  logic [1:0]  req_sew = '0;
  logic [11:0] req_vl = '0;
  logic        rd_en;
  logic [2:0]  rd_lane;
  logic [2:0]  rd_bank;
  logic [6:0]  rd_addr;
  logic [63:0] rd_data;
  logic        elem_valid;
  logic        elem_ready = 1'b0;
  logic [63:0] elem_data;
  logic [10:0] elem_idx;
  logic        elem_last;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] mem [8][5][128];
  logic [63:0] q_data [$];
  int          q_idx  [$];
  bit          q_last [$];
  int          q_lane [$];
  int          q_bank [$];
  int          q_addr [$];

  int first_rd = -1, first_ev = -1, last_hs = -1, done_cyc = -1, err_cyc = -1;
  int done_cnt = 0, err_cnt = 0, hs_cnt = 0, stall_cnt = 0, rd_cnt = 0;
  bit rp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  vrf_elem_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_vreg   (req_vreg),
    .req_sew    (req_sew),
    .req_vl     (req_vl),
    .rd_en      (rd_en),
    .rd_lane    (rd_lane),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_data  (elem_data),
    .elem_idx   (elem_idx),
    .elem_last  (elem_last),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // VRF with one-cycle read latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_en ? mem[rd_lane][rd_bank][rd_addr] : 64'h0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int l, input int b, input int a);
    return {16'hBEEF, 8'(l), 8'(b), 8'(a), 24'h000000};
  endfunction

  // Monitor: pops expectations on each read strobe and element handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        if (q_lane.size() == 0) begin
          chk("rd_unexpected", 64'(rd_addr), 64'hFFFF);
        end else begin
          chk("rd_lane", 64'(rd_lane), 64'(q_lane.pop_front()));
          chk("rd_bank", 64'(rd_bank), 64'(q_bank.pop_front()));
          chk("rd_addr", 64'(rd_addr), 64'(q_addr.pop_front()));
        end
      end
      if (elem_valid) begin
        if (first_ev < 0) first_ev = cyc;
        if (q_data.size() == 0) begin
          chk("elem_unexpected", 64'(elem_idx), 64'hFFFF);
        end else if (elem_ready) begin
          hs_cnt++;
          if (elem_last) last_hs = cyc;
          chk("elem_data", elem_data, q_data.pop_front());
          chk("elem_idx", 64'(elem_idx), 64'(q_idx.pop_front()));
          chk("elem_last", 64'(elem_last), 64'(q_last.pop_front()));
        end else begin
          stall_cnt++;
          chk("stall_data", elem_data, q_data[0]);
          chk("stall_idx", 64'(elem_idx), 64'(q_idx[0]));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
        chk("err_req_ready", 64'(req_ready), 64'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_elem(input logic [63:0] d, input int i, input bit l);
    q_data.push_back(d);
    q_idx.push_back(i);
    q_last.push_back(l);
  endtask

  task automatic push_rd(input int l, input int b, input int a);
    q_lane.push_back(l);
    q_bank.push_back(b);
    q_addr.push_back(a);
  endtask

  task automatic send_req(input int vreg, input int sew, input int vl, output int t);
    first_rd = -1; first_ev = -1; last_hs = -1; done_cyc = -1; err_cyc = -1;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_vreg  = 5'(vreg);
    req_sew   = 2'(sew);
    req_vl    = 12'(vl);
    req_valid = 1'b1;
    tick();
    t = cyc;
    req_valid = 1'b0;
  endtask

  // Confirms req_ready is low during the done cycle and back the next one
  task automatic after_done();
    chk("ready_in_done", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_done", 64'(req_ready), 64'd1);
    tick();
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
    if (got) after_done();
    else tick();
  endtask

  initial begin
    int t, d0, h0, s0, r0, e0;
    for (int l = 0; l < 8; l++)
      for (int b = 0; b < 5; b++)
        for (int a = 0; a < 128; a++)
          mem[l][b][a] = pat(l, b, a);

    // Reset values
    tick(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_elem_valid", 64'(elem_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_elem_data", elem_data, 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    rst_n = 1'b1;
    tick();

    // SEW=64, vreg=3, vl=8: one block per lane, bank 0, addr 3*7
    for (int l = 0; l < 8; l++) begin
      mem[l][0][21] = 64'hC0DE_0000_0000_0000 + 64'(l);
      push_rd(l, 0, 21);
      push_elem(64'hC0DE_0000_0000_0000 + 64'(l), l, l == 7);
    end
    elem_ready = 1'b1;
    h0 = hs_cnt;
    send_req(3, 3, 8, t);
    wait_done("t1", 100);
    chk("t1_first_rd", 64'(first_rd), 64'(t));
    chk("t1_first_ev", 64'(first_ev), 64'(t + 2));
    chk("t1_done_lat", 64'(done_cyc), 64'(last_hs + 1));
    chk("t1_hs", 64'(hs_cnt - h0), 64'd8);

    // SEW=8, vl=13 across two words
    mem[0][0][7] = 64'h0807060504030201;
    mem[1][0][7] = 64'h100F0E0D0C0B0A09;
    push_rd(0, 0, 7);
    push_rd(1, 0, 7);
    for (int i = 0; i < 13; i++) push_elem(64'(i + 1), i, i == 12);
    r0 = rd_cnt;
    send_req(1, 0, 13, t);
    wait_done("t2", 100);
    chk("t2_reads", 64'(rd_cnt - r0), 64'd2);

    // Backpressure SEW=16, vl=4, ready 1-0-0-1
    mem[0][0][14] = 64'h4444_3333_2222_1111;
    push_rd(0, 0, 14);
    push_elem(64'h1111, 0, 1'b0);
    push_elem(64'h2222, 1, 1'b0);
    push_elem(64'h3333, 2, 1'b0);
    push_elem(64'h4444, 3, 1'b1);
    h0 = hs_cnt; s0 = stall_cnt; d0 = done_cnt;
    send_req(2, 1, 4, t);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
        elem_ready = rp[i % 4];
        @(negedge clk);
        if (done) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      chk("t3_done_seen", 64'(got), 64'd1);
      if (got) after_done();
    end
    elem_ready = 1'b1;
    tick(); tick();
    chk("t3_hs", 64'(hs_cnt - h0), 64'd4);
    chk("t3_stalled", 64'(stall_cnt > s0), 64'd1);
    chk("t3_done_once", 64'(done_cnt - d0), 64'd1);

    // Wrap: SEW=64, vl=41 -> block 40 returns to lane 0, bank 0, addr+1
    for (int b = 0; b < 41; b++) begin
      push_rd(b % 8, (b / 8) % 5, b / 40);
      push_elem(pat(b % 8, (b / 8) % 5, b / 40), b, b == 40);
    end
    send_req(0, 3, 41, t);
    wait_done("t4", 400);

    // vl=0 -> immediate done, no reads
    send_req(7, 2, 0, t);
    wait_done("t5_vl0", 10);
    chk("t5_vl0_done_cyc", 64'(done_cyc), 64'(t));
    chk("t5_vl0_no_rd", 64'(first_rd), 64'(-1));

    // Illegal lengths -> err pulse, no reads, no done
    e0 = err_cnt; d0 = done_cnt;
    send_req(9, 3, 257, t);
    tick(); tick(); tick();
    chk("t6_err_cyc", 64'(err_cyc), 64'(t));
    chk("t6_err_cnt", 64'(err_cnt - e0), 64'd1);
    chk("t6_no_rd", 64'(first_rd), 64'(-1));
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    send_req(9, 0, 2049, t);
    tick(); tick();
    chk("t6b_err_cyc", 64'(err_cyc), 64'(t));
    chk("t6b_no_rd", 64'(first_rd), 64'(-1));

    // Request while busy is dropped
    push_rd(0, 0, 35);
    push_rd(1, 0, 35);
    push_elem(pat(0, 0, 35), 0, 1'b0);
    push_elem(pat(1, 0, 35), 1, 1'b1);
    d0 = done_cnt;
    send_req(5, 3, 2, t);
    req_vreg = 5'd6; req_vl = 12'd5; req_valid = 1'b1;
    chk("t7_busy_not_ready", 64'(req_ready), 64'd0);
    tick(); tick(); tick();
    req_valid = 1'b0;
    wait_done("t7", 50);
    tick(); tick(); tick();
    chk("t7_done_once", 64'(done_cnt - d0), 64'd1);

    // Reset during EMIT of SEW=32, vl=16
    for (int i = 0; i < 16; i++) begin
      logic [63:0] w;
      w = pat(i / 2, 0, 28);
      push_elem((i % 2) ? {32'h0, w[63:32]} : {32'h0, w[31:0]}, i, i == 15);
    end
    for (int b = 0; b < 8; b++) push_rd(b, 0, 28);
    send_req(4, 2, 16, t);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (elem_valid && elem_ready && elem_idx == 11'd2) begin
          got = 1'b1;
          break;
        end
      end
      chk("t8_reached_idx2", 64'(got), 64'd1);
    end
    tick();
    chk("t8_in_emit", 64'(elem_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_elem_valid", 64'(elem_valid), 64'd0);
    chk("t8_rst_elem_data", elem_data, 64'd0);
    chk("t8_rst_elem_idx", 64'(elem_idx), 64'd0);
    chk("t8_rst_rd_en", 64'(rd_en), 64'd0);
    chk("t8_rst_req_ready", 64'(req_ready), 64'd1);
    q_data.delete(); q_idx.delete(); q_last.delete();
    q_lane.delete(); q_bank.delete(); q_addr.delete();
    d0 = done_cnt;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("t8_no_done_after_rst", 64'(done_cnt - d0), 64'd0);
    for (int i = 0; i < 16; i++) begin
      logic [63:0] w;
      w = pat(i / 2, 0, 28);
      push_elem((i % 2) ? {32'h0, w[63:32]} : {32'h0, w[31:0]}, i, i == 15);
    end
    for (int b = 0; b < 8; b++) push_rd(b, 0, 28);
    h0 = hs_cnt;
    send_req(4, 2, 16, t);
    wait_done("t8b", 100);
    chk("t8b_hs", 64'(hs_cnt - h0), 64'd16);
    chk("t8b_first_ev", 64'(first_ev), 64'(t + 2));

    chk("end_q_elem_empty", 64'(q_data.size()), 64'd0);
    chk("end_q_rd_empty", 64'(q_lane.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
